// File: rtl/sgmii_pcs_pkg.sv
// Code-group constants and sequencer state encoding for the SGMII PCS transmit path.
// Latency: n/a (package).
// Backpressure: n/a (package).
//
// Code groups are 9 bits wide: {K flag, octet}. This is the form the 8b10b
// encoder takes on its data input.
package sgmii_pcs_pkg;

  localparam logic [8:0] K28_5          = 9'h1BC;  // comma, first group of every ordered set
  localparam logic [8:0] K27_7          = 9'h1FB;  // /S/ start of packet
  localparam logic [8:0] K29_7          = 9'h1FD;  // /T/ end of packet
  localparam logic [8:0] K23_7          = 9'h1F7;  // /R/ carrier extend
  localparam logic [8:0] K30_7          = 9'h1FE;  // /V/ error propagation
  localparam logic [8:0] D5_6           = 9'h0C5;  // /I1/ second group
  localparam logic [8:0] D16_2          = 9'h050;  // /I2/ second group
  localparam logic [8:0] PREAMBLE_OCTET = 9'h055;
  localparam logic [8:0] SFD_OCTET      = 9'h0D5;
  localparam logic [8:0] PAD_OCTET      = 9'h000;

  typedef enum logic [3:0] {
    IDLE,
    START,
    PREAMBLE,
    SFD,
    PAYLOAD,
    PAD,
    DRAIN,
    END_T,
    END_R
  } tx_state_e;

  // Increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sgmii_tx_sequencer.sv
// SGMII/1000BASE-X PCS transmit sequencer: idles, /S/ preamble SFD payload pad /T/ /R/, IPG.
// Latency: one clock from an accepted payload byte to code_out. code_out is registered.
// Backpressure: tx_ready is high only in SFD, PAYLOAD (until tx_last is taken) and DRAIN.
//
// Ports:
//   clock, reset_n           125 MHz code-group clock, async active-low reset
//   tx_data/valid/last/ready byte-stream frame source handshake
//   code_out, disp_out       {K, octet} and running disparity to the external 8b10b encoder
//   enc_dispout              encoder disparity result, fed back every clock
//   busy, underrun           frame-in-flight flag, one-clock underrun pulse
//   frames_sent              count of frames closed with a good /T/
import sgmii_pcs_pkg::*;

module sgmii_tx_sequencer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 60,
  parameter int IPG_LEN      = 12
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  input  logic        tx_last,
  output logic        tx_ready,
  output logic [8:0]  code_out,
  output logic        disp_out,
  input  logic        enc_dispout,
  output logic        busy,
  output logic        underrun,
  output logic [15:0] frames_sent
);

  // Idle ordered sets are two groups long, so the gap is kept even.
  localparam int         IPG_EVEN = ((IPG_LEN + 1) / 2) * 2;
  localparam logic [7:0] IPG_SAT  = 8'(IPG_EVEN);
  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] MIN_PAY  = 8'(MIN_PAYLOAD);

  // r_state always describes the code group currently on code_out. The
  // group for the next clock is computed from the next state and loaded
  // into r_code on the same edge as r_state.
  tx_state_e   r_state;
  tx_state_e   w_next_state;

  logic        r_even;      // parity of the group on code_out (1 = even)
  logic        r_disp;
  logic [8:0]  r_code;
  logic        r_underrun;
  logic [15:0] r_frames;
  logic [7:0]  r_gap;       // idle groups on the line since /R/, including the current one
  logic [7:0]  r_cnt;       // payload octets accepted, plus pad octets emitted
  logic [7:0]  r_pre;       // preamble groups emitted so far
  logic        r_last_acc;  // tx_last taken; the last byte is on code_out now
  logic        r_bad;       // frame hit an underrun, /T/ must not count it

  logic        w_ready;
  logic        w_accept;
  logic        w_underrun;
  logic        w_busy;
  logic [8:0]  w_code_nxt;
  logic        w_data_state;

  // ---------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        // r_even low means the group after this one is even, which is the
        // only slot where /S/ may go.
        if (!r_even && tx_valid && (r_gap >= IPG_SAT)) begin
          w_next_state = START;
        end
      end
      START: begin
        w_next_state = (PRE_LAST != 8'd0) ? PREAMBLE : SFD;
      end
      PREAMBLE: begin
        if (r_pre >= PRE_LAST) begin
          w_next_state = SFD;
        end
      end
      SFD: begin
        w_next_state = tx_valid ? PAYLOAD : DRAIN;
      end
      PAYLOAD: begin
        if (r_last_acc) begin
          w_next_state = (r_cnt < MIN_PAY) ? PAD : END_T;
        end else if (!tx_valid) begin
          w_next_state = DRAIN;
        end else begin
          w_next_state = PAYLOAD;
        end
      end
      PAD: begin
        if (r_cnt >= MIN_PAY) begin
          w_next_state = END_T;
        end
      end
      DRAIN: begin
        if (tx_valid && tx_last) begin
          w_next_state = END_T;
        end
      end
      END_T: begin
        w_next_state = END_R;
      end
      END_R: begin
        // A second /R/ is needed when the next slot is odd, so that idle
        // resumes on an even group.
        if (!r_even) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------
  always_comb begin
    w_data_state = (r_state == SFD) || (r_state == PAYLOAD);
    w_ready      = (r_state == SFD) || (r_state == DRAIN) ||
                   ((r_state == PAYLOAD) && !r_last_acc);
    w_accept     = w_ready && tx_valid;
    w_underrun   = w_ready && !tx_valid && w_data_state;
    w_busy       = (r_state != IDLE);

    w_code_nxt = K28_5;
    case (w_next_state)
      // The disparity held while K28.5 is on the line picks the second
      // group of the idle ordered set.
      IDLE:     w_code_nxt = r_even ? (r_disp ? D5_6 : D16_2) : K28_5;
      START:    w_code_nxt = K27_7;
      PREAMBLE: w_code_nxt = PREAMBLE_OCTET;
      SFD:      w_code_nxt = SFD_OCTET;
      PAYLOAD:  w_code_nxt = {1'b0, tx_data};
      PAD:      w_code_nxt = PAD_OCTET;
      DRAIN:    w_code_nxt = K30_7;
      END_T:    w_code_nxt = K29_7;
      END_R:    w_code_nxt = K23_7;
      default:  w_code_nxt = K28_5;
    endcase
  end

  // ---------------------------------------------------------------
  // Code-group, alignment, disparity and frame bookkeeping
  // ---------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_even     <= 1'b1;
      r_disp     <= 1'b0;
      r_code     <= K28_5;
      r_underrun <= 1'b0;
      r_frames   <= 16'd0;
      r_gap      <= 8'd0;
      r_cnt      <= 8'd0;
      r_pre      <= 8'd0;
      r_last_acc <= 1'b0;
      r_bad      <= 1'b0;
    end else begin
      r_even     <= !r_even;
      r_disp     <= enc_dispout;
      r_code     <= w_code_nxt;
      r_underrun <= w_underrun;

      if (r_state == END_R && w_next_state == IDLE) begin
        r_gap <= 8'd1;
      end else if (r_state == IDLE) begin
        r_gap <= (r_gap >= IPG_SAT) ? IPG_SAT : r_gap + 8'd1;
      end

      if (r_state == START) begin
        r_pre <= 8'd1;
      end else if (r_state == PREAMBLE) begin
        r_pre <= r_pre + 8'd1;
      end

      if (r_state == START) begin
        r_cnt <= 8'd0;
      end else if (w_accept && w_data_state) begin
        r_cnt <= sat_inc8(r_cnt);
      end else if (w_next_state == PAD) begin
        r_cnt <= sat_inc8(r_cnt);
      end

      if (r_state == START) begin
        r_last_acc <= 1'b0;
      end else if (w_accept && w_data_state && tx_last) begin
        r_last_acc <= 1'b1;
      end

      if (r_state == START) begin
        r_bad <= 1'b0;
      end else if (w_underrun) begin
        r_bad <= 1'b1;
      end

      if (r_state == END_T && !r_bad) begin
        r_frames <= r_frames + 16'd1;
      end
    end
  end

  assign tx_ready    = w_ready;
  assign busy        = w_busy;
  assign code_out    = r_code;
  assign disp_out    = r_disp;
  assign underrun    = r_underrun;
  assign frames_sent = r_frames;

endmodule

// File: tb/tb_sgmii_tx_sequencer.sv
// Self-checking bench for sgmii_tx_sequencer: table of frame records plus hand sequences.
module tb_sgmii_tx_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_last = 1'b0;
  logic        enc_dispout = 1'b0;
  logic        tx_ready;
  logic [8:0]  code_out;
  logic        disp_out;
  logic        busy;
  logic        underrun;
  logic [15:0] frames_sent;

  sgmii_tx_sequencer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .code_out    (code_out),
    .disp_out    (disp_out),
    .enc_dispout (enc_dispout),
    .busy        (busy),
    .underrun    (underrun),
    .frames_sent (frames_sent)
  );

  always #4 clock = ~clock;

  // Expected parity of the group on code_out: even out of reset, toggling every clock.
  logic tb_even;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) tb_even <= 1'b1;
    else          tb_even <= ~tb_even;
  end

  int checks = 0;
  int passes = 0;
  logic last_enc = 1'b0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];

  typedef struct {
    int len;        // payload bytes (ignored when drop_after != 0)
    int drop_after; // bytes sent before tx_valid drops (0 = no drop)
    int drop_cyc;   // clocks with tx_valid low
    int tail;       // bytes sent after the drop, last one carries tx_last
    bit keep;       // hold tx_valid high after tx_last (back-to-back)
    int groups;     // expected code groups while busy
    int pads;       // expected pad octets
    int frames;     // expected frames_sent after the frame
    int urs;        // expected underrun pulses
    int wmin;       // idle groups before /S/, lower bound
    int wmax;       // idle groups before /S/, upper bound
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    enc_dispout = 1'($urandom_range(0, 1));
    last_enc = enc_dispout;
    @(posedge clock);
    #1;
  endtask

  task automatic run_frame(input int k, input vec_t v);
    int total, b, hold, ur_cnt, ur_idx, pad_err, wait_cyc, mism, idx;
    bit seen, fin, fire;
    total = (v.drop_after != 0) ? v.drop_after + v.tail : v.len;
    exp_q.delete();
    got_q.delete();
    exp_q.push_back(9'h1FB);
    for (int i = 0; i < 6; i++) exp_q.push_back(9'h055);
    exp_q.push_back(9'h0D5);
    if (v.drop_after != 0) begin
      for (int i = 0; i < v.drop_after; i++) exp_q.push_back(9'(i));
      for (int i = 0; i < v.drop_cyc + v.tail - 1; i++) exp_q.push_back(9'h1FE);
    end else begin
      for (int i = 0; i < v.len; i++) exp_q.push_back(9'(i & 8'hFF));
      for (int i = 0; i < v.pads; i++) exp_q.push_back(9'h000);
    end
    exp_q.push_back(9'h1FD);
    exp_q.push_back(9'h1F7);
    if ((exp_q.size() % 2) == 1) exp_q.push_back(9'h1F7);

    b = 0; hold = 0; ur_cnt = 0; ur_idx = -1; pad_err = 0; wait_cyc = 0;
    seen = 0; fin = 0;
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    tx_last  = (total == 1);
    for (int n = 0; n < 400 && !fin; n++) begin
      if (underrun) begin
        ur_cnt++;
        ur_idx = got_q.size();
      end
      if (busy) begin
        if (!seen) begin
          seen = 1;
          chk($sformatf("f%0d_s_on_even", k), tb_even, 1'b1);
        end
        idx = got_q.size();
        if (v.drop_after == 0 && idx >= 8 + v.len && idx < 8 + v.len + v.pads && tx_ready)
          pad_err++;
        got_q.push_back(code_out);
      end else if (seen) begin
        fin = 1;
      end else begin
        wait_cyc++;
      end
      if (!fin) begin
        fire = tx_valid && tx_ready;
        tick();
        if (fire) begin
          if (tx_last) begin
            tx_last  = 1'b0;
            tx_data  = 8'h00;
            tx_valid = v.keep;
          end else begin
            b++;
            tx_data = 8'(b);
            tx_last = (b == total - 1);
            if (v.drop_after != 0 && b == v.drop_after) begin
              tx_valid = 1'b0;
              hold = v.drop_cyc;
            end
          end
        end else if (hold > 0) begin
          hold--;
          if (hold == 0) tx_valid = 1'b1;
        end
      end
    end
    chk($sformatf("f%0d_completed", k), fin, 1'b1);
    chk($sformatf("f%0d_group_count", k), got_q.size(), v.groups);
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) mism++;
    chk($sformatf("f%0d_stream_mismatches", k), mism, 0);
    chk($sformatf("f%0d_frames_sent", k), frames_sent, v.frames);
    chk($sformatf("f%0d_underruns", k), ur_cnt, v.urs);
    if (v.urs != 0) chk($sformatf("f%0d_underrun_pos", k), ur_idx, 8 + v.drop_after);
    chk($sformatf("f%0d_ready_in_pad", k), pad_err, 0);
    chk($sformatf("f%0d_idle_before_s_in_range", k),
        (wait_cyc >= v.wmin && wait_cyc <= v.wmax), 1'b1);
  endtask

  initial begin
    logic d_before;
    int cnt;
    //           len drop dc tail keep grp pads frm ur wmin wmax
    vecs[0] = '{64, 0, 0, 0, 1'b0, 74,  0, 1, 0,  1,    1};
    vecs[1] = '{10, 0, 0, 0, 1'b1, 70, 50, 2, 0, 12,   14};
    vecs[2] = '{60, 0, 0, 0, 1'b0, 70,  0, 3, 0, 12,   14};
    vecs[3] = '{61, 0, 0, 0, 1'b0, 72,  0, 4, 0, 12,   14};
    vecs[4] = '{ 0, 5, 1, 3, 1'b0, 18,  0, 4, 1, 12,   14};
    vecs[5] = '{ 1, 0, 0, 0, 1'b0, 70, 59, 5, 0, 12,   14};

    #2 reset_n = 1'b0;
    #12;
    chk("reset_code", code_out, 9'h1BC);
    chk("reset_ready", tx_ready, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_underrun", underrun, 1'b0);
    chk("reset_frames", frames_sent, 16'd0);
    chk("reset_disp", disp_out, 1'b0);
    #8 reset_n = 1'b1;

    // Idle: K28.5 on even, odd group picked by disparity held during that K28.5.
    d_before = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_disp_follow", disp_out, last_enc);
      chk("idle_busy", busy, 1'b0);
      if (tb_even) begin
        chk("idle_even_k28_5", code_out, 9'h1BC);
        d_before = disp_out;
      end else begin
        chk("idle_odd_group", code_out, d_before ? 9'h0C5 : 9'h050);
      end
    end

    // First frame: tx_valid raised while an odd group is on the line.
    if (tb_even) tick();
    for (int k = 0; k < 6; k++) run_frame(k, vecs[k]);

    // Reset in the middle of a payload.
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    tx_last  = 1'b0;
    cnt = 0;
    for (int n = 0; n < 100 && cnt < 12; n++) begin
      tick();
      if (busy) cnt++;
    end
    chk("mid_frame_reached_payload", tx_ready, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_reset_code", code_out, 9'h1BC);
    chk("mid_reset_ready", tx_ready, 1'b0);
    chk("mid_reset_busy", busy, 1'b0);
    chk("mid_reset_frames", frames_sent, 16'd0);
    tx_valid = 1'b0;
    @(posedge clock);
    #3 reset_n = 1'b1;
    tick();
    chk("post_reset_odd_group", code_out, 9'h050);
    chk("post_reset_frames", frames_sent, 16'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
